// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, fault detection and the IF/ID pipeline register.
// Instruction memory sits outside and answers PCF combinationally on InstrF.
module fetch_stage #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'hBFC00000,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_LAST      = 32'hBFC00FFF,
  parameter logic [31:0]              NOP_INSTR     = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  output logic [ADDRESS_WIDTH-1:0] PCF,
  input  logic [31:0]              InstrF,
  output logic [31:0]              InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD,
  output logic                     FaultF
);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FAULT = 1'b1;

  // Highest address at which a whole 4-byte word still fits inside the ROM.
  localparam logic [ADDRESS_WIDTH-1:0] ROM_LAST_WORD = ROM_LAST - ADDRESS_WIDTH'(3);

  typedef struct packed {
    logic [31:0]              instr;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  logic [0:0]               state, state_next;
  logic [ADDRESS_WIDTH-1:0] pc_plus4, pc_next;
  logic                     in_rom, bad_target;
  ifid_t                    ifid_q, ifid_d;

  assign pc_plus4   = PCF + ADDRESS_WIDTH'(4);
  assign in_rom     = (PCF >= RESET_PC) && (PCF <= ROM_LAST_WORD);
  assign bad_target = PCSrcE && (PCTargetE[1:0] != 2'b00);

  // A fetch from outside the ROM is never handed to decode; the PC freezes
  // on the offending address so the fault can be inspected.
  always_comb begin
    pc_next    = PCF;
    state_next = state;
    ifid_d     = ifid_q;
    if (state == S_FAULT || !in_rom) begin
      state_next = S_FAULT;
      ifid_d     = BUBBLE;
    end else begin
      if (FlushD)       ifid_d = BUBBLE;
      else if (!StallD) ifid_d = '{instr: InstrF, pc: PCF, pc_plus4: pc_plus4, valid: 1'b1};

      // A redirect wins over StallF; a misaligned target is refused and the PC holds.
      if (bad_target)   state_next = S_FAULT;
      else if (PCSrcE)  pc_next    = PCTargetE;
      else if (!StallF) pc_next    = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCF    <= RESET_PC;
      state  <= S_RUN;
      ifid_q <= BUBBLE;
    end else begin
      PCF    <= pc_next;
      state  <= state_next;
      ifid_q <= ifid_d;
    end
  end

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;
  assign FaultF   = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control traffic,
// all compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hBFC00000;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0, rst = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] PCF, InstrF, InstrD, PCD, PCPlus4D;
  logic        ValidD, FaultF;
  int          n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: a distinct word for every address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction
  assign InstrF = rom_word(PCF);

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .PCF(PCF), .InstrF(InstrF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FaultF(FaultF)
  );

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
  logic        m_valid, m_fault;

  function automatic logic [129:0] observed();
    return {PCF, InstrD, PCD, PCPlus4D, ValidD, FaultF};
  endfunction
  function automatic logic [129:0] expected();
    return {m_pc, m_instr, m_pcd, m_pc4d, m_valid, m_fault};
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_fault = 1'b0;
    m_instr = NOP; m_pcd = '0; m_pc4d = '0; m_valid = 1'b0;
  endtask

  // Apply one cycle of controls, advance one edge, and update the model.
  task automatic step(input logic sf, input logic sd, input logic fd, input logic ps,
                      input logic [31:0] tgt);
    logic [31:0] n_pc, n_i, n_d, n_4;
    logic        n_v, n_f, in_rom;
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    n_pc = m_pc; n_i = m_instr; n_d = m_pcd; n_4 = m_pc4d; n_v = m_valid; n_f = m_fault;
    in_rom = ({1'b0, m_pc} >= 33'h0BFC00000) && ({1'b0, m_pc} + 33'd3 <= 33'h0BFC00FFF);
    if (m_fault || !in_rom) begin
      n_f = 1'b1; n_i = NOP; n_d = '0; n_4 = '0; n_v = 1'b0;
    end else begin
      if (fd) begin
        n_i = NOP; n_d = '0; n_4 = '0; n_v = 1'b0;
      end else if (!sd) begin
        n_i = rom_word(m_pc); n_d = m_pc; n_4 = 32'((64'(m_pc) + 4) % 64'h1_0000_0000); n_v = 1'b1;
      end
      if (ps && (tgt % 4 != 0)) n_f = 1'b1;
      else if (ps)              n_pc = tgt;
      else if (!sf)             n_pc = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
    end
    @(posedge clk); #1;
    m_pc = n_pc; m_instr = n_i; m_pcd = n_d; m_pc4d = n_4; m_valid = n_v; m_fault = n_f;
  endtask

  task automatic do_reset();
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk); #2;
    rst = 1'b1; model_reset();
    #1;
    n_checks++;
    if (observed() !== expected()) begin
      n_errors++; $display("FAIL reset_async: got %h want %h", observed(), expected());
    end
    @(posedge clk); #1;
    n_checks++;
    if (PCF !== RST_PC || ValidD !== 1'b0 || FaultF !== 1'b0 || InstrD !== NOP) begin
      n_errors++; $display("FAIL reset_held: PCF %h ValidD %b FaultF %b InstrD %h", PCF, ValidD, FaultF, InstrD);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, '0);
      n_checks++;
      if (PCF !== RST_PC + 32'(4 * (i + 1)) || InstrD !== rom_word(RST_PC + 32'(4 * i)) ||
          PCD !== RST_PC + 32'(4 * i) || ValidD !== 1'b1) begin
        n_errors++; $display("FAIL seq_%0d: PCF %h InstrD %h PCD %h ValidD %b", i, PCF, InstrD, PCD, ValidD);
      end
      n_checks++;
      if (observed() !== expected()) begin
        n_errors++; $display("FAIL seq_model_%0d: got %h want %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(0, 0, 0, 0, '0); step(0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, '0);
      n_checks++;
      if (PCF !== 32'hBFC00008 || InstrD !== rom_word(32'hBFC00004) || PCD !== 32'hBFC00004) begin
        n_errors++; $display("FAIL stall_%0d: PCF %h InstrD %h PCD %h", i, PCF, InstrD, PCD);
      end
    end
    step(0, 0, 0, 0, '0);
    n_checks++;
    if (PCF !== 32'hBFC0000C || InstrD !== rom_word(32'hBFC00008)) begin
      n_errors++; $display("FAIL stall_resume: PCF %h InstrD %h", PCF, InstrD);
    end
    // StallF alone: the same fetch address is loaded into decode again.
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    n_checks++;
    if (PCF !== 32'hBFC0000C || PCD !== 32'hBFC0000C || InstrD !== rom_word(32'hBFC0000C) || ValidD !== 1'b1) begin
      n_errors++; $display("FAIL stallf_only: PCF %h PCD %h InstrD %h ValidD %b", PCF, PCD, InstrD, ValidD);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step(0, 0, 0, 0, '0);
    step(1, 0, 1, 1, 32'hBFC00100);
    n_checks++;
    if (PCF !== 32'hBFC00100 || InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
      n_errors++; $display("FAIL redirect: PCF %h InstrD %h ValidD %b PCD %h", PCF, InstrD, ValidD, PCD);
    end
    step(0, 0, 0, 0, '0);
    n_checks++;
    if (PCF !== 32'hBFC00104 || InstrD !== rom_word(32'hBFC00100) || PCPlus4D !== 32'hBFC00104) begin
      n_errors++; $display("FAIL redirect_follow: PCF %h InstrD %h PCPlus4D %h", PCF, InstrD, PCPlus4D);
    end
    // Flush wins over StallD.
    step(0, 1, 1, 0, '0);
    n_checks++;
    if (ValidD !== 1'b0 || InstrD !== NOP || PCF !== 32'hBFC00108) begin
      n_errors++; $display("FAIL flush_over_stall: ValidD %b InstrD %h PCF %h", ValidD, InstrD, PCF);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 32'hBFC00102);
    n_checks++;
    if (PCF !== 32'hBFC00004 || FaultF !== 1'b1) begin
      n_errors++; $display("FAIL misaligned: PCF %h FaultF %b", PCF, FaultF);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 32'hBFC00200);
      n_checks++;
      if (FaultF !== 1'b1 || ValidD !== 1'b0 || PCF !== 32'hBFC00004) begin
        n_errors++; $display("FAIL fault_sticky_%0d: FaultF %b ValidD %b PCF %h", i, FaultF, ValidD, PCF);
      end
    end
  endtask

  task automatic test_async_reset();
    // Entered while still in FAULT from the previous scenario.
    #2; rst = 1'b1;
    #1;
    n_checks++;
    if (PCF !== RST_PC || FaultF !== 1'b0 || ValidD !== 1'b0) begin
      n_errors++; $display("FAIL async_reset: PCF %h FaultF %b ValidD %b", PCF, FaultF, ValidD);
    end
    @(negedge clk); rst = 1'b0; model_reset();
    step(0, 0, 0, 0, '0);
    n_checks++;
    if (PCF !== 32'hBFC00004 || InstrD !== rom_word(RST_PC) || ValidD !== 1'b1) begin
      n_errors++; $display("FAIL post_reset: PCF %h InstrD %h ValidD %b", PCF, InstrD, ValidD);
    end
  endtask

  task automatic test_rom_end();
    bit done = 0;
    do_reset();
    for (int i = 0; i < 1100 && !done; i++) begin
      step(0, 0, 0, 0, '0);
      n_checks++;
      if (observed() !== expected()) begin
        n_errors++; $display("FAIL rom_run_%0d: got %h want %h", i, observed(), expected());
      end
      if (PCF === 32'hBFC01000) done = 1;
    end
    n_checks++;
    if (!done || FaultF !== 1'b0 || InstrD !== rom_word(32'hBFC00FFC) || ValidD !== 1'b1) begin
      n_errors++; $display("FAIL rom_end_reach: done %0d FaultF %b InstrD %h ValidD %b", done, FaultF, InstrD, ValidD);
    end
    step(0, 0, 0, 0, '0);
    n_checks++;
    if (FaultF !== 1'b1 || ValidD !== 1'b0 || PCF !== 32'hBFC01000) begin
      n_errors++; $display("FAIL rom_end_fault: FaultF %b ValidD %b PCF %h", FaultF, ValidD, PCF);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 120; i++) begin
        logic [31:0] tgt;
        logic        ps;
        ps  = ($urandom_range(0, 7) == 0);
        tgt = RST_PC + 32'(4 * $urandom_range(0, 1023));
        if ($urandom_range(0, 29) == 0) tgt = tgt | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 39) == 0) tgt = 32'h00001000;
        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, ps, tgt);
        n_checks++;
        if (observed() !== expected()) begin
          n_errors++; $display("FAIL random_%0d_%0d: got %h want %h", r, i, observed(), expected());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned();
    test_async_reset();
    test_rom_end();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, the PC and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'hBFC00000, the boot fetch address.
REQ-003 SHALL have parameter ROM_LAST, default 32'hBFC00FFF, the last valid byte of the instruction ROM.
REQ-004 SHALL have parameter NOP_INSTR, default 32'h00000013, the bubble instruction (addi x0,x0,0).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port StallF, input, 1, hold the PC.
REQ-008 SHALL have port StallD, input, 1, hold the IF/ID register.
REQ-009 SHALL have port FlushD, input, 1, load a bubble into IF/ID.
REQ-010 SHALL have port PCSrcE, input, 1, redirect request from execute.
REQ-011 SHALL have port PCTargetE, input, ADDRESS_WIDTH, redirect target.
REQ-012 SHALL have port PCF, output, ADDRESS_WIDTH, current fetch address, driven to instruction memory A.
REQ-013 SHALL have port InstrF, input, 32, instruction word returned combinationally by instruction memory for PCF.
REQ-014 SHALL have ports InstrD, PCD, PCPlus4D, outputs, 32/ADDRESS_WIDTH/ADDRESS_WIDTH, the IF/ID register contents.
REQ-015 SHALL have port ValidD, output, 1, high when InstrD is a real fetched instruction.
REQ-016 SHALL have port FaultF, output, 1, sticky fetch-fault flag.

Function
REQ-017 SHALL implement a two-state machine: RUN and FAULT.
REQ-018 SHALL compute PCPlus4F = PCF + 4, modulo 2^ADDRESS_WIDTH (0xFFFFFFFC wraps to 0x00000000).
REQ-019 SHALL, in RUN, select next PC by priority: PCSrcE -> PCTargetE; else StallF -> hold; else PCPlus4F.
REQ-020 SHALL let PCSrcE override StallF in the same cycle.
REQ-021 SHALL treat a PCSrcE target with bits [1:0] != 0 as a fault: PC holds, state -> FAULT next edge.
REQ-022 SHALL treat a PCF outside [RESET_PC, ROM_LAST-3] in RUN as a fault: state -> FAULT next edge; the IF/ID load that edge is a bubble.
REQ-023 SHALL, in FAULT, hold PCF, assert FaultF, and load a bubble every edge; only rst leaves FAULT.
REQ-024 SHALL update IF/ID by priority: FlushD -> bubble; else StallD -> hold; else load {InstrF, PCF, PCPlus4F}, ValidD=1.
REQ-025 SHALL define a bubble as InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-026 SHALL let FlushD override StallD.
REQ-027 SHALL give PCF-to-InstrD latency of exactly one edge when unstalled.
REQ-028 SHALL keep StallF and StallD independent; StallF without StallD loads the same PCF into IF/ID again.
REQ-029 SHALL never drive a fetch address not on a 4-byte boundary.

Reset
REQ-030 SHALL, while rst is high, force PCF=RESET_PC, state=RUN, FaultF=0, and IF/ID to a bubble, independent of clk.
REQ-031 SHALL, on the first edge after rst deasserts with no stall/flush/redirect, load InstrD with the word at RESET_PC, ValidD=1, and advance PCF to RESET_PC+4.
REQ-032 SHALL let rst asserted mid-fault or mid-stall immediately override all other state.

Verification
REQ-033 SHALL cover: reset release, ROM words 0..2 distinct, no stalls -> PCF 0xBFC00000, 0xBFC00004, 0xBFC00008; InstrD lags PCF by one edge; ValidD=1 from the first edge.
REQ-034 SHALL cover: StallF=StallD=1 for 3 cycles at PCF=0xBFC00008 -> PCF, InstrD, PCD unchanged for 3 cycles; resume at 0xBFC0000C.
REQ-035 SHALL cover: PCSrcE=1, PCTargetE=0xBFC00100 with StallF=1 and FlushD=1 -> next PCF=0xBFC00100, InstrD=0x00000013, ValidD=0.
REQ-036 SHALL cover: PCSrcE=1, PCTargetE=0xBFC00102 -> PCF holds; FaultF=1 next edge and stays 1; ValidD=0 thereafter until rst.
REQ-037 SHALL cover: sequential run to PCF=0xBFC00FFC then 0xBFC01000 -> FaultF=1 on the edge after PCF=0xBFC01000; no valid InstrD from 0xBFC01000.
REQ-038 SHALL cover: rst pulsed asynchronously (between edges) during FAULT -> PCF=0xBFC00000, FaultF=0, ValidD=0 before the next clk edge.
